// File: rtl/crc6_pkg.sv
// Shared CRC-6 definitions used by both the frame transmitter and the byte checker.
package crc6_pkg;

  // Default seed byte; only bits [5:0] take part in the equations.
  localparam logic [7:0] CRC6_SEED = 8'h37;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StStart = 3'd1,
    StData  = 3'd2,
    StCrc   = 3'd3,
    StStop  = 3'd4
  } tx_state_e;

  // Per-byte CRC-6 with a fixed seed; there is no chaining between bytes.
  function automatic logic [5:0] crc6_byte(input logic [7:0] d, input logic [5:0] c);
    logic [5:0] n;
    n[0] = d[5] ^ d[2] ^ d[1] ^ d[0] ^ c[0] ^ c[3];
    n[1] = d[6] ^ d[5] ^ d[3] ^ d[0] ^ c[1] ^ c[3] ^ c[4];
    n[2] = d[7] ^ d[6] ^ d[5] ^ d[4] ^ d[2] ^ d[0] ^ c[0] ^ c[2] ^ c[3] ^ c[4] ^ c[5];
    n[3] = d[7] ^ d[6] ^ d[3] ^ d[2] ^ d[0] ^ c[0] ^ c[1] ^ c[4] ^ c[5];
    n[4] = d[7] ^ d[4] ^ d[3] ^ d[1] ^ c[1] ^ c[2] ^ c[5];
    n[5] = d[4] ^ d[1] ^ d[0] ^ c[2];
    return n;
  endfunction

endpackage

// File: rtl/crc_frame_tx_if.sv
// Byte producer handshake into the frame transmitter.
interface crc_frame_tx_if;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/crc6_byte_gen.sv
// Combinational CRC-6 of one byte with a fixed seed; shared with the checker side.
module crc6_byte_gen
  import crc6_pkg::*;
#(
  parameter logic [7:0] Seed = CRC6_SEED
) (
  input  logic [7:0] data_i,
  output logic [5:0] crc_o
);

  // Pure function of the byte; seed bits [7:6] are ignored by design.
  always_comb begin
    crc_o = crc6_byte(data_i, Seed[5:0]);
  end

endmodule

// File: rtl/crc_frame_tx.sv
// Serialises start bit, data byte (LSB first), 6-bit CRC (LSB first) and stop bit.
module crc_frame_tx
  import crc6_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter logic [7:0]  CRC_SEED     = CRC6_SEED
) (
  input  logic          clk,
  input  logic          rst_n,
  crc_frame_tx_if.slave in_if,
  output logic          tx_out,
  output logic          busy,
  output logic [5:0]    crc_out,
  output logic          frame_done
);

  localparam int unsigned     CntW    = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CntW-1:0] BaudMax = CntW'(CLKS_PER_BIT - 1);

  tx_state_e       state_q, state_d;
  logic [CntW-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic [7:0]      data_q, data_d;
  logic [5:0]      crc_q, crc_d;
  logic            tx_q, tx_d;
  logic            done_q, done_d;

  logic [5:0]      crc_new;
  logic            accept;
  logic            bit_end;
  logic [7:0]      crc_pad;

  crc6_byte_gen #(
    .Seed (CRC_SEED)
  ) u_crc_gen (
    .data_i (in_if.in_data),
    .crc_o  (crc_new)
  );

  // Next-state, counters and capture of the accepted byte.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    data_d     = data_q;
    crc_d      = crc_q;
    done_d     = 1'b0;
    bit_end    = (baud_cnt_q == BaudMax);
    accept     = in_if.in_valid && (state_q == StIdle);

    if (state_q != StIdle) begin
      baud_cnt_d = bit_end ? '0 : baud_cnt_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d    = StStart;
          data_d     = in_if.in_data;
          crc_d      = crc_new;
          baud_cnt_d = '0;
          bit_idx_d  = 3'd0;
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d   = StData;
          bit_idx_d = 3'd0;
        end
      end
      StData: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd7) begin
            state_d   = StCrc;
            bit_idx_d = 3'd0;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      StCrc: begin
        if (bit_end) begin
          if (bit_idx_q == 3'd5) begin
            state_d   = StStop;
            bit_idx_d = 3'd0;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      StStop: begin
        if (bit_end) begin
          state_d   = StIdle;
          bit_idx_d = 3'd0;
          done_d    = 1'b1;
        end
      end
      default: begin
        state_d    = StIdle;
        baud_cnt_d = '0;
        bit_idx_d  = 3'd0;
      end
    endcase
  end

  // Line level is derived from the next state so tx_out can be a plain flop.
  always_comb begin
    crc_pad = {2'b00, crc_d};
    tx_d    = 1'b1;
    case (state_d)
      StStart: tx_d = 1'b0;
      StData:  tx_d = data_d[bit_idx_d];
      StCrc:   tx_d = crc_pad[bit_idx_d];
      default: tx_d = 1'b1;
    endcase
  end

  // All state; reset abandons any frame and drives the line high at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      baud_cnt_q <= '0;
      bit_idx_q  <= 3'd0;
      data_q     <= 8'h00;
      crc_q      <= 6'h00;
      tx_q       <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      data_q     <= data_d;
      crc_q      <= crc_d;
      tx_q       <= tx_d;
      done_q     <= done_d;
    end
  end

  assign in_if.in_ready = (state_q == StIdle);
  assign busy           = (state_q != StIdle);
  assign tx_out         = tx_q;
  assign crc_out        = crc_q;
  assign frame_done     = done_q;

endmodule

// File: tb/tb_crc_frame_tx.sv
// Directed bench for crc_frame_tx with 4 and 1 clocks per bit.
module tb_crc_frame_tx;

  logic       clk;
  logic       rst_n;
  logic       tx4, busy4, done4;
  logic [5:0] crc4;
  logic       tx1, busy1, done1;
  logic [5:0] crc1;

  int pass_cnt  = 0;
  int total_cnt = 0;

  crc_frame_tx_if if4 ();
  crc_frame_tx_if if1 ();

  crc_frame_tx #(.CLKS_PER_BIT(4)) dut4 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_if      (if4),
    .tx_out     (tx4),
    .busy       (busy4),
    .crc_out    (crc4),
    .frame_done (done4)
  );

  crc_frame_tx #(.CLKS_PER_BIT(1)) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_if      (if1),
    .tx_out     (tx1),
    .busy       (busy1),
    .crc_out    (crc1),
    .frame_done (done1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Line bits in transmit order: start, data LSB first, crc LSB first, stop.
  function automatic logic [15:0] frame_bits(input logic [7:0] d, input logic [5:0] c);
    return {1'b1, c, d, 1'b0};
  endfunction

  function automatic logic [63:0] expand4(input logic [15:0] b);
    logic [63:0] r;
    for (int n = 0; n < 64; n++) r[n] = b[n / 4];
    return r;
  endfunction

  // Receiver-side checker model with seed 0x37.
  function automatic logic [5:0] checker_crc(input logic [7:0] d);
    logic [7:0] c;
    logic [5:0] n;
    c = 8'h37;
    n[0] = d[5] ^ d[2] ^ d[1] ^ d[0] ^ c[0] ^ c[3];
    n[1] = d[6] ^ d[5] ^ d[3] ^ d[0] ^ c[1] ^ c[3] ^ c[4];
    n[2] = d[7] ^ d[6] ^ d[5] ^ d[4] ^ d[2] ^ d[0] ^ c[0] ^ c[2] ^ c[3] ^ c[4] ^ c[5];
    n[3] = d[7] ^ d[6] ^ d[3] ^ d[2] ^ d[0] ^ c[0] ^ c[1] ^ c[4] ^ c[5];
    n[4] = d[7] ^ d[4] ^ d[3] ^ d[1] ^ c[1] ^ c[2] ^ c[5];
    n[5] = d[4] ^ d[1] ^ d[0] ^ c[2];
    return n;
  endfunction

  task automatic wait_ready4();
    for (int i = 0; i < 200; i++) begin
      if (if4.in_ready === 1'b1) return;
      @(negedge clk);
    end
    $display("FAIL wait_ready4: in_ready=%b required 1 within 200 cycles", if4.in_ready);
    $fatal(1, "in_ready timeout");
  endtask

  // Offers one byte to dut4 and records the 64 frame cycles plus the first idle cycle.
  task automatic run_frame4(input logic [7:0] b, output logic [63:0] samp, output int dones,
                            output int busy_low, output logic [2:0] end_st);
    @(negedge clk);
    wait_ready4();
    if4.in_data  = b;
    if4.in_valid = 1'b1;
    @(posedge clk);
    #1;
    if4.in_valid = 1'b0;
    if4.in_data  = ~b;
    samp     = '0;
    dones    = 0;
    busy_low = 0;
    for (int n = 0; n < 64; n++) begin
      @(negedge clk);
      samp[n] = tx4;
      if (done4 === 1'b1) dones++;
      if (busy4 !== 1'b1) busy_low++;
    end
    @(negedge clk);
    end_st = {done4, if4.in_ready, tx4};
  endtask

  task automatic test_reset();
    if4.in_valid = 1'b0;
    if4.in_data  = 8'h00;
    if1.in_valid = 1'b0;
    if1.in_data  = 8'h00;
    rst_n = 1'b1;
    #2;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++;
    if (tx4 !== 1'b1) $display("FAIL reset_tx: got %b want 1", tx4); else pass_cnt++;
    total_cnt++;
    if (if4.in_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", if4.in_ready);
    else pass_cnt++;
    total_cnt++;
    if (busy4 !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy4); else pass_cnt++;
    total_cnt++;
    if (crc4 !== 6'h00) $display("FAIL reset_crc: got %h want 00", crc4); else pass_cnt++;
    total_cnt++;
    if (done4 !== 1'b0) $display("FAIL reset_done: got %b want 0", done4); else pass_cnt++;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_byte_00();
    logic [63:0] samp;
    int          dones, busy_low;
    logic [2:0]  end_st;
    run_frame4(8'h00, samp, dones, busy_low, end_st);
    total_cnt++;
    if (crc4 !== 6'h31) $display("FAIL crc_00: got %h want 31", crc4); else pass_cnt++;
    total_cnt++;
    if (samp !== expand4(frame_bits(8'h00, 6'h31)))
      $display("FAIL line_00: got %h want %h", samp, expand4(frame_bits(8'h00, 6'h31)));
    else pass_cnt++;
    total_cnt++;
    if (dones != 0) $display("FAIL early_done_00: got %0d pulses want 0", dones); else pass_cnt++;
    total_cnt++;
    if (busy_low != 0) $display("FAIL busy_00: got %0d idle cycles want 0", busy_low);
    else pass_cnt++;
    total_cnt++;
    if (end_st !== 3'b111) $display("FAIL end_00: got {done,ready,tx}=%b want 111", end_st);
    else pass_cnt++;
  endtask

  task automatic test_byte_ff();
    logic [63:0] samp;
    int          dones, busy_low;
    logic [2:0]  end_st;
    logic [5:0]  line_crc;
    run_frame4(8'hFF, samp, dones, busy_low, end_st);
    for (int i = 0; i < 6; i++) line_crc[i] = samp[(9 + i) * 4 + 2];
    total_cnt++;
    if (crc4 !== 6'h19) $display("FAIL crc_ff: got %h want 19", crc4); else pass_cnt++;
    total_cnt++;
    if (line_crc !== 6'b011001) $display("FAIL crcbits_ff: got %b want 011001", line_crc);
    else pass_cnt++;
    total_cnt++;
    if (samp !== expand4(frame_bits(8'hFF, 6'h19)))
      $display("FAIL line_ff: got %h want %h", samp, expand4(frame_bits(8'hFF, 6'h19)));
    else pass_cnt++;
    total_cnt++;
    if (dones != 0) $display("FAIL early_done_ff: got %0d pulses want 0", dones); else pass_cnt++;
    total_cnt++;
    if (end_st !== 3'b111) $display("FAIL end_ff: got {done,ready,tx}=%b want 111", end_st);
    else pass_cnt++;
  endtask

  task automatic test_byte_01();
    logic [63:0] samp;
    int          dones, busy_low;
    logic [2:0]  end_st;
    logic [7:0]  line_data;
    run_frame4(8'h01, samp, dones, busy_low, end_st);
    for (int i = 0; i < 8; i++) line_data[i] = samp[(1 + i) * 4 + 2];
    total_cnt++;
    if (crc4 !== 6'h1E) $display("FAIL crc_01: got %h want 1e", crc4); else pass_cnt++;
    total_cnt++;
    if (line_data !== 8'h01) $display("FAIL databits_01: got %h want 01", line_data);
    else pass_cnt++;
    total_cnt++;
    if (samp !== expand4(frame_bits(8'h01, 6'h1E)))
      $display("FAIL line_01: got %h want %h", samp, expand4(frame_bits(8'h01, 6'h1E)));
    else pass_cnt++;
    total_cnt++;
    if (busy_low != 0) $display("FAIL busy_01: got %0d idle cycles want 0", busy_low);
    else pass_cnt++;
    total_cnt++;
    if (end_st !== 3'b111) $display("FAIL end_01: got {done,ready,tx}=%b want 111", end_st);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [7:0]  bytes [3];
    logic [5:0]  crcs  [3];
    logic [63:0] samp;
    logic        early;
    bytes[0] = 8'h00; bytes[1] = 8'hFF; bytes[2] = 8'h01;
    crcs[0]  = 6'h31; crcs[1]  = 6'h19; crcs[2]  = 6'h1E;
    @(negedge clk);
    wait_ready4();
    if4.in_data  = bytes[0];
    if4.in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      if4.in_data = 8'hC3;  // junk while busy must never be captured
      samp  = '0;
      early = 1'b0;
      for (int n = 0; n < 64; n++) begin
        @(negedge clk);
        samp[n] = tx4;
        if (if4.in_ready === 1'b1) early = 1'b1;
        if (n == 40 && k < 2) if4.in_data = bytes[k + 1];
      end
      total_cnt++;
      if (crc4 !== crcs[k]) $display("FAIL b2b_crc%0d: got %h want %h", k, crc4, crcs[k]);
      else pass_cnt++;
      total_cnt++;
      if (samp !== expand4(frame_bits(bytes[k], crcs[k])))
        $display("FAIL b2b_line%0d: got %h want %h", k, samp,
                 expand4(frame_bits(bytes[k], crcs[k])));
      else pass_cnt++;
      total_cnt++;
      if (early !== 1'b0) $display("FAIL b2b_ready_busy%0d: got %b want 0", k, early);
      else pass_cnt++;
      @(negedge clk);
      total_cnt++;
      if ({done4, if4.in_ready} !== 2'b11)
        $display("FAIL b2b_ready_done%0d: got {done,ready}=%b want 11", k, {done4, if4.in_ready});
      else pass_cnt++;
      if (k == 2) if4.in_valid = 1'b0;
    end
    @(negedge clk);
    total_cnt++;
    if ({busy4, tx4, done4} !== 3'b010)
      $display("FAIL b2b_after: got {busy,tx,done}=%b want 010", {busy4, tx4, done4});
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_frame();
    logic seen_done;
    @(negedge clk);
    wait_ready4();
    if4.in_data  = 8'h00;
    if4.in_valid = 1'b1;
    @(posedge clk);
    #1;
    if4.in_valid = 1'b0;
    repeat (21) @(negedge clk);
    total_cnt++;
    if ({busy4, tx4} !== 2'b10) $display("FAIL mid_before: got {busy,tx}=%b want 10", {busy4, tx4});
    else pass_cnt++;
    rst_n = 1'b0;
    #1;
    total_cnt++;
    if (tx4 !== 1'b1) $display("FAIL mid_tx: got %b want 1", tx4); else pass_cnt++;
    total_cnt++;
    if (busy4 !== 1'b0) $display("FAIL mid_busy: got %b want 0", busy4); else pass_cnt++;
    total_cnt++;
    if (crc4 !== 6'h00) $display("FAIL mid_crc: got %h want 00", crc4); else pass_cnt++;
    seen_done = done4;
    repeat (3) @(negedge clk) if (done4 === 1'b1) seen_done = 1'b1;
    rst_n = 1'b1;
    repeat (70) @(negedge clk) if (done4 === 1'b1) seen_done = 1'b1;
    total_cnt++;
    if (seen_done !== 1'b0) $display("FAIL mid_no_done: got %b want 0", seen_done);
    else pass_cnt++;
    total_cnt++;
    if (if4.in_ready !== 1'b1) $display("FAIL mid_ready: got %b want 1", if4.in_ready);
    else pass_cnt++;
  endtask

  task automatic test_cpb1();
    logic [15:0] s;
    logic [7:0]  rec_byte;
    logic [5:0]  rec_crc;
    logic [2:0]  end_st;
    int          dones;
    int          waited;
    @(negedge clk);
    waited = 0;
    while (if1.in_ready !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (if1.in_ready !== 1'b1) begin
      $display("FAIL cpb1_ready: got %b want 1 within 200 cycles", if1.in_ready);
      $fatal(1, "in_ready timeout");
    end
    if1.in_data  = 8'hA5;
    if1.in_valid = 1'b1;
    @(posedge clk);
    #1;
    if1.in_valid = 1'b0;
    if1.in_data  = 8'h00;
    dones = 0;
    for (int n = 0; n < 16; n++) begin
      @(negedge clk);
      s[n] = tx1;
      if (done1 === 1'b1) dones++;
    end
    @(negedge clk);
    end_st   = {done1, if1.in_ready, tx1};
    rec_byte = s[8:1];
    rec_crc  = s[14:9];
    total_cnt++;
    if ({s[15], s[0]} !== 2'b10) $display("FAIL cpb1_framing: got {stop,start}=%b want 10",
                                          {s[15], s[0]});
    else pass_cnt++;
    total_cnt++;
    if (rec_byte !== 8'hA5) $display("FAIL cpb1_byte: got %h want a5", rec_byte); else pass_cnt++;
    total_cnt++;
    if (rec_crc !== 6'h08) $display("FAIL cpb1_linecrc: got %h want 08", rec_crc); else pass_cnt++;
    total_cnt++;
    if (crc1 !== 6'h08) $display("FAIL cpb1_crc_out: got %h want 08", crc1); else pass_cnt++;
    total_cnt++;
    if (checker_crc(rec_byte) !== rec_crc)
      $display("FAIL cpb1_checker: got %h want %h", rec_crc, checker_crc(rec_byte));
    else pass_cnt++;
    total_cnt++;
    if (dones != 0) $display("FAIL cpb1_early_done: got %0d want 0", dones); else pass_cnt++;
    total_cnt++;
    if (end_st !== 3'b111) $display("FAIL cpb1_end: got {done,ready,tx}=%b want 111", end_st);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_byte_00();
    test_byte_ff();
    test_byte_01();
    test_back_to_back();
    test_reset_mid_frame();
    test_cpb1();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/crc_frame_tx.md
Name: crc_frame_tx

Overview:
Transmit-side partner of the CRC-6 byte checker. Accepts one data byte through a valid/ready handshake and computes its 6-bit CRC in the same cycle. The CRC uses the checker's per-byte equations with the fixed seed c = 8'b00110111; only c[5:0] is used. The block then serialises a 16-bit frame onto a single line: start bit, 8 data bits, 6 CRC bits, stop bit. Sits between the byte producer and the serial link feeding the receiver/checker.

Parameters:
CLKS_PER_BIT, 4, clock cycles each serial bit is held; legal range >= 1
CRC_SEED, 8'h37, CRC seed byte; only bits [5:0] enter the equations

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_data  input  8  byte to transmit
in_valid  input  1  producer offers in_data
in_ready  output  1  block can accept a byte
tx_out  output  1  serial line; idles high
busy  output  1  frame in progress
crc_out  output  6  CRC of the last accepted byte
frame_done  output  1  one-cycle pulse at frame end

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: tx_out=1, in_ready=1, busy=0, crc_out=6'h00, frame_done=0, state=IDLE, all counters 0.
- Reset mid-frame: frame is abandoned. Line returns high immediately. No frame_done pulse. Captured byte/CRC are cleared.
- CRC equations (d = byte, c = CRC_SEED), each term XORed:
  - n0 = d5,d2,d1,d0,c0,c3
  - n1 = d6,d5,d3,d0,c1,c3,c4
  - n2 = d7,d6,d5,d4,d2,d0,c0,c2,c3,c4,c5
  - n3 = d7,d6,d3,d2,d0,c0,c1,c4,c5
  - n4 = d7,d4,d3,d1,c1,c2,c5
  - n5 = d4,d1,d0,c2
- The seed is constant per byte; there is no chaining between bytes.
- Handshake:
  - Accept occurs on a rising edge with in_valid & in_ready.
  - in_ready = (state==IDLE), combinational from state.
  - On accept, register shift data <= in_data and crc_out <= n[5:0]. Go to START.
  - in_data may change freely after the accept edge.
- States:
  - IDLE: tx_out=1. Go to START on accept.
  - START: tx_out=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: tx_out=data[bit_idx], LSB first, bit_idx 0..7. Each bit is held CLKS_PER_BIT cycles. After bit 7 go to CRC.
  - CRC: tx_out=crc_out[bit_idx], LSB first, bit_idx 0..5, then STOP.
  - STOP: tx_out=1 for CLKS_PER_BIT cycles, then IDLE. Pulse frame_done for one cycle, coincident with the first IDLE cycle.
- Counters:
  - baud_cnt counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary. Width is $clog2(CLKS_PER_BIT)+1.
  - bit_idx is 3 bits and resets to 0 on every state change.
- Latency and timing:
  - tx_out is registered; the start bit appears in the cycle after the accept edge.
  - Frame length is exactly 16*CLKS_PER_BIT cycles from start-bit first cycle to stop-bit last cycle.
  - busy = (state != IDLE).
- Back-to-back: an accept in the frame_done cycle starts the next START in the following cycle. There is no extra idle bit.
- in_valid while busy is ignored; the producer must hold it.
- CLKS_PER_BIT=1: one cycle per bit, so the counter is always 0.

Decomposition:
- Shared package crc6_pkg:
  - CRC6_SEED constant (8'h37).
  - tx state enum (IDLE, START, DATA, CRC, STOP), 3-bit encoding.
  - Function crc6_byte(d, c) implementing n0..n5. The checker reuses it so both ends match.
- One sub-module, crc6_byte_gen: purely combinational wrapper around crc6_byte. It is instantiated here and usable by the checker.

Test Plan:
- Reset with in_valid=0 -> tx_out=1, in_ready=1, busy=0, crc_out=0x00. Assert rst_n low mid-frame -> tx_out=1 immediately, no frame_done.
- Send 0x00, CLKS_PER_BIT=4 -> crc_out=0x31. Line shows 0 (start), 0x00 LSB first, then 1,0,0,0,1,1, then 1 (stop). Each bit is 4 cycles, 64 cycles total. frame_done pulses once.
- Send 0xFF -> crc_out=0x19. CRC bits on line: 1,0,0,1,1,0.
- Send 0x01 -> crc_out=0x1E. Data bits on line: 1,0,0,0,0,0,0,0.
- Hold in_valid=1 with three bytes queued -> three frames with no gap. Each in_ready rise is coincident with frame_done. Bytes that change while busy are not sampled.
- CLKS_PER_BIT=1, send 0xA5 -> 16-cycle frame. The receiver-side checker model reports match on the recovered byte and CRC.
